// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: default clock and line
// rate, the baud divisor helper, 8N1 frame constants and the transmitter
// FSM state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 50000000;
  localparam int DEFAULT_BAUD     = 9600;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clocks per bit; integer division truncates (5208 at 50 MHz / 9600).
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Synchronous byte FIFO, first-word-fall-through: rd_data always shows the
// oldest entry, so a reader samples it in the same cycle it pops.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (pointers and count only)
//   wr_en    write request; ignored while full
//   wr_data  byte to store
//   rd_en    read request; ignored while empty
//   rd_data  oldest stored byte (undefined while empty)
//   full     count == DEPTH
//   empty    count == 0
//   count    entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_BITS-1:0]     wr_data,
  input  logic                     rd_en,
  output logic [DATA_BITS-1:0]     rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr_fire;
  logic                 rd_fire;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the bookkeeping does.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 RS232 transmitter. Bytes enter a FIFO over a valid/ready
// handshake and are serialised LSB first with an integrated baud counter.
// Consecutive queued bytes go out back to back with no idle clock.
//
// Ports:
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset; abandons any frame at once
//   tx_data     byte offered by the producer
//   tx_valid    producer offers tx_data this cycle
//   tx_ready    FIFO not full (combinational from the FIFO count)
//   rs232_tx    serial line, idle high, registered
//   tx_busy     a frame is on the line, registered
//   fifo_count  entries held in the FIFO, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          rs232_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_d;
  logic                 busy_d;
  logic                 baud_end;
  logic                 pop;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign baud_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = rs232_tx;
    busy_d  = tx_busy;
    pop     = 1'b0;

    // The counter only runs inside a frame and restarts at every bit edge.
    if (state_q != IDLE) begin
      cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            tx_d    = STOP_BIT;
            state_d = STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            tx_d    = START_BIT;
            bit_d   = '0;
            state_d = START;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      rs232_tx <= STOP_BIT;
      tx_busy  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      rs232_tx <= tx_d;
      tx_busy  <= busy_d;
    end
  end

  // The shift register is pure data and is always loaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered at CLK_FREQ=1000, BAUD=100
// (10 clocks per bit). A transaction-level model (byte queue plus a frame
// phase counter) predicts the line, busy flag, FIFO count and ready each
// clock; directed steps add checks for the specific scenarios.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 16;
  localparam int BIT_CLKS   = 10;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rs232_tx;
  logic       tx_busy;
  logic [4:0] fifo_count;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rs232_tx   (rs232_tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Reference model: accepted bytes waiting, and clocks into the current
  // frame (-1 when the line is idle).
  logic [7:0] q[$];
  int         phase = -1;
  logic [7:0] cur_byte = 8'h00;
  bit         last_push = 1'b0;

  int busy_cnt, busy_run, max_run, low_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  function automatic logic model_line();
    int k;
    if (phase < 0) return 1'b1;
    k = phase / BIT_CLKS;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur_byte[k-1];
  endfunction

  task automatic reset_stats();
    busy_cnt = 0;
    busy_run = 0;
    max_run  = 0;
    low_cnt  = 0;
  endtask

  // Advance one clock: update the model for the coming edge, then compare.
  task automatic step();
    int         qsz;
    bit         accept;
    logic [7:0] din;
    qsz    = q.size();
    accept = (tx_valid === 1'b1) && (qsz < FIFO_DEPTH);
    din    = tx_data;
    if (phase < 0 || phase == FRAME_CLKS - 1) begin
      if (qsz > 0) begin
        cur_byte = q.pop_front();
        phase    = 0;
      end else begin
        phase = -1;
      end
    end else begin
      phase++;
    end
    if (accept) q.push_back(din);
    last_push = accept;
    @(posedge clk);
    #1;
    cycle++;
    check("line",  32'(rs232_tx),   32'(model_line()));
    check("busy",  32'(tx_busy),    32'(phase >= 0));
    check("count", 32'(fifo_count), 32'(q.size()));
    check("ready", 32'(tx_ready),   32'(q.size() < FIFO_DEPTH));
    if (tx_busy === 1'b1) begin
      busy_cnt++;
      busy_run++;
      if (busy_run > max_run) max_run = busy_run;
    end else begin
      busy_run = 0;
    end
    if (rs232_tx === 1'b0) low_cnt++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((phase >= 0 || q.size() > 0) && guard < 4000) begin
      step();
      guard++;
    end
    check("drain_done", 32'(phase < 0 && q.size() == 0), 32'd1);
  endtask

  initial begin
    int wait_n;
    int guard;

    rst_n    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    reset_stats();

    // Reset state
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_line",  32'(rs232_tx),   32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(tx_ready),   32'd1);
    rst_n = 1'b1;
    repeat (3) step();

    // Single byte 0x55
    reset_stats();
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("single_count_n",  32'(fifo_count), 32'd1);
    check("single_line_n",   32'(rs232_tx),   32'd1);
    step();
    check("single_line_n1",  32'(rs232_tx),   32'd0);
    check("single_count_n1", 32'(fifo_count), 32'd0);
    repeat (110) step();
    check("single_busy_len", 32'(busy_cnt), 32'd100);
    check("single_low_clks", 32'(low_cnt),  32'd50);
    drain();

    // Back-to-back 0xA3, 0x0F
    reset_stats();
    tx_valid = 1'b1;
    tx_data  = 8'hA3;
    step();
    tx_data  = 8'h0F;
    step();
    tx_valid = 1'b0;
    repeat (220) step();
    check("b2b_busy_total", 32'(busy_cnt), 32'd200);
    check("b2b_busy_run",   32'(max_run),  32'd200);
    drain();

    // Fill and back-pressure with 0x00..0x11
    reset_stats();
    tx_valid = 1'b1;
    for (int b = 0; b <= 17; b++) begin
      tx_data = 8'(b);
      wait_n  = 0;
      do begin
        step();
        wait_n++;
      end while (!last_push && wait_n < 300);
      check("fill_accept", 32'(last_push), 32'd1);
      if (b == 16) begin
        check("fill_full_count", 32'(fifo_count), 32'd16);
        check("fill_full_ready", 32'(tx_ready),   32'd0);
      end
      if (b == 17) check("fill_wait_0x11", 32'(wait_n), 32'd86);
    end
    tx_valid = 1'b0;
    drain();

    // Push/pop collision at fifo_count = 3
    reset_stats();
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    check("collide_pre_count", 32'(fifo_count), 32'd3);
    guard = 0;
    while (phase != FRAME_CLKS - 1 && guard < 200) begin
      step();
      guard++;
    end
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("collide_count",  32'(fifo_count), 32'd3);
    check("collide_accept", 32'(last_push),  32'd1);
    drain();

    // Reset during bit3 of 0x00
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    guard = 0;
    while (phase != 45 && guard < 200) begin
      step();
      guard++;
    end
    check("midrst_pre_line", 32'(rs232_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line",  32'(rs232_tx),   32'd1);
    check("midrst_busy",  32'(tx_busy),    32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_ready", 32'(tx_ready),   32'd1);
    q.delete();
    phase = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_stats();
    repeat (200) step();
    check("postrst_busy", 32'(busy_cnt), 32'd0);
    check("postrst_low",  32'(low_cnt),  32'd0);

    // Data extremes
    reset_stats();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    drain();
    check("ff_low_clks",  32'(low_cnt),  32'd10);
    check("ff_busy_len",  32'(busy_cnt), 32'd100);
    reset_stats();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    drain();
    check("zero_low_clks", 32'(low_cnt),  32'd90);
    check("zero_busy_len", 32'(busy_cnt), 32'd100);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
